// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// Holds the FSM state encoding and the bit-counter width function.
package piso_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  function automatic int PISO_CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Word-in / bit-out signal bundle for piso_shift_tx.
// Handshake: a word moves on any falling clock edge that samples in_valid & in_ready both high;
// the producer holds in_valid/in_data stable until then, and in_ready never depends on in_valid.
interface piso_shift_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;
  piso_state_e      dbg_state;

  modport master (
    output in_data,
    output in_valid,
    output shift_en,
    input  in_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy,
    input  dbg_state
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  shift_en,
    output in_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy,
    output dbg_state
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one word: clears on load, counts enabled shifts,
// flags the last position and saturates there instead of wrapping.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = PISO_CNT_W(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign term = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !term) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it out
// one bit per enabled falling edge, streaming back-to-back words without an idle bit.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  piso_shift_tx_if.slave   bus
);

  localparam int CNT_W = PISO_CNT_W(WIDTH);

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             sout_q;
  logic             sout_d;
  logic             sout_valid_q;
  logic             sout_valid_d;
  logic             sout_last_q;
  logic             sout_last_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_term;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;

  // The register always keeps the bit on the wire at its output end,
  // so the next bit is simply the output end of the shifted register.
  function automatic logic out_end(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  assign in_ready = !reset &&
                    ((state_q == PISO_IDLE) ||
                     ((state_q == PISO_SHIFT) && cnt_term && bus.shift_en));
  assign accept   = bus.in_valid && in_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (bit_cnt),
    .term  (cnt_term)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    sout_last_d  = sout_last_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    unique case (state_q)
      PISO_IDLE: begin
        if (accept) begin
          state_d      = PISO_SHIFT;
          shreg_d      = bus.in_data;
          sout_d       = out_end(bus.in_data);
          sout_valid_d = 1'b1;
          sout_last_d  = 1'b0;
          cnt_clr      = 1'b1;
        end else begin
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
          sout_last_d  = 1'b0;
        end
      end

      PISO_SHIFT: begin
        if (bus.shift_en) begin
          if (!cnt_term) begin
            shreg_d     = shreg_shifted;
            sout_d      = out_end(shreg_shifted);
            sout_last_d = (bit_cnt == CNT_W'(WIDTH - 2));
            cnt_inc     = 1'b1;
          end else if (accept) begin
            // Next word lands in the slot the last bit just vacated: no gap.
            shreg_d      = bus.in_data;
            sout_d       = out_end(bus.in_data);
            sout_valid_d = 1'b1;
            sout_last_d  = 1'b0;
            cnt_clr      = 1'b1;
          end else begin
            state_d      = PISO_IDLE;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            sout_last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = PISO_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= PISO_IDLE;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.sout_last  = sout_last_q;
  assign bus.busy       = (state_q == PISO_SHIFT);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share one stimulus stream
// and are checked every cycle against a word/index-level model plus a word scoreboard.
module tb_piso_shift_tx;
  import piso_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(W)) ifa ();
  piso_shift_tx_if #(.WIDTH(W)) ifb ();

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the word on the wire, which bit of it is showing, and whether one is active.
  logic [W-1:0] m_word   = '0;
  int           m_idx    = 0;
  logic         m_active = 1'b0;
  logic         m_acc    = 1'b0;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [W-1:0] acc_a = '0;
  logic [W-1:0] acc_b = '0;
  int           cnt_a = 0;
  int           cnt_b = 0;
  int           words_ok = 0;

  logic [63:0]  log_a = '0;
  logic [63:0]  log_b = '0;
  int           nval = 0;
  int           nlast = 0;
  int           rdy_hits = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic log_clear();
    log_a    = '0;
    log_b    = '0;
    nval     = 0;
    nlast    = 0;
    rdy_hits = 0;
  endtask

  task automatic m_load(input logic [W-1:0] d);
    m_word   = d;
    m_idx    = 0;
    m_active = 1'b1;
    exp_qa.push_back(d);
    exp_qb.push_back(d);
  endtask

  task automatic consume_a(input logic b, input logic last);
    acc_a = {acc_a[W-2:0], b};
    cnt_a++;
    if (last) begin
      check_eq("a_word_len", 64'(cnt_a), 64'(W));
      check_eq("a_word_pending", 64'(exp_qa.size() > 0), 64'(1));
      if (exp_qa.size() > 0) begin
        logic [W-1:0] e;
        e = exp_qa.pop_front();
        check_eq("a_word", 64'(acc_a), 64'(e));
        if (acc_a == e) words_ok++;
      end
      cnt_a = 0;
    end
  endtask

  task automatic consume_b(input logic b, input logic last);
    acc_b = {b, acc_b[W-1:1]};
    cnt_b++;
    if (last) begin
      check_eq("b_word_len", 64'(cnt_b), 64'(W));
      check_eq("b_word_pending", 64'(exp_qb.size() > 0), 64'(1));
      if (exp_qb.size() > 0) begin
        logic [W-1:0] e;
        e = exp_qb.pop_front();
        check_eq("b_word", 64'(acc_b), 64'(e));
        if (acc_b == e) words_ok++;
      end
      cnt_b = 0;
    end
  endtask

  // One clock: check registered outputs at the rising edge, drive inputs, check in_ready,
  // then advance the model to what the coming falling edge should produce.
  task automatic step(input logic v, input logic [W-1:0] d, input logic sen, input logic rst);
    logic sa, va, la, sb, vb, lb, exp_rdy, eb_a, eb_b, el;
    @(posedge clk);
    sa = ifa.sout; va = ifa.sout_valid; la = ifa.sout_last;
    sb = ifb.sout; vb = ifb.sout_valid; lb = ifb.sout_last;
    eb_a = m_active ? m_word[W-1-m_idx] : 1'b0;
    eb_b = m_active ? m_word[m_idx] : 1'b0;
    el   = m_active && (m_idx == W-1);
    check_eq("a_sout",  64'(sa), 64'(eb_a));
    check_eq("b_sout",  64'(sb), 64'(eb_b));
    check_eq("a_valid", 64'(va), 64'(m_active));
    check_eq("b_valid", 64'(vb), 64'(m_active));
    check_eq("a_last",  64'(la), 64'(el));
    check_eq("b_last",  64'(lb), 64'(el));
    check_eq("a_busy",  64'(ifa.busy), 64'(m_active));
    check_eq("b_busy",  64'(ifb.busy), 64'(m_active));
    check_eq("a_state", 64'(ifa.dbg_state), 64'(m_active));

    if (va) begin
      log_a = {log_a[62:0], sa};
      log_b = {log_b[62:0], sb};
      nval++;
      if (la) nlast++;
    end
    if (!rst && va && sen) consume_a(sa, la);
    if (!rst && vb && sen) consume_b(sb, lb);

    reset        = rst;
    ifa.in_valid = v;   ifb.in_valid = v;
    ifa.in_data  = d;   ifb.in_data  = d;
    ifa.shift_en = sen; ifb.shift_en = sen;
    #1;
    exp_rdy = !rst && (!m_active || ((m_idx == W-1) && sen));
    check_eq("a_ready", 64'(ifa.in_ready), 64'(exp_rdy));
    check_eq("b_ready", 64'(ifb.in_ready), 64'(exp_rdy));
    if (v && ifa.in_ready) rdy_hits++;

    m_acc = v && exp_rdy;
    if (rst) begin
      m_active = 1'b0;
      m_idx    = 0;
      exp_qa.delete();
      exp_qb.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else if (!m_active) begin
      if (m_acc) m_load(d);
    end else if (sen) begin
      if (m_idx < W-1) m_idx++;
      else if (m_acc) m_load(d);
      else m_active = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    logic         pend;
    logic [W-1:0] rd;
    int           ok0;

    reset = 1'b1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.in_data  = '0;   ifb.in_data  = '0;
    ifa.shift_en = 1'b0; ifb.shift_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, in_ready held low while reset is asserted.
    step(1'b1, 8'h33, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);

    // Single word A5 with shift_en held high; LSB-first instance sends the same pattern.
    log_clear();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(9);
    check_eq("a5_nval", 64'(nval), 64'd8);
    check_eq("a5_nlast", 64'(nlast), 64'd1);
    check_eq("a5_msb_bits", log_a & 64'hFF, 64'hA5);
    check_eq("a5_lsb_bits", log_b & 64'hFF, 64'hA5);

    // 01: LSB-first sends a 1 then seven 0s.
    log_clear();
    step(1'b1, 8'h01, 1'b1, 1'b0);
    idle(9);
    check_eq("01_msb_bits", log_a & 64'hFF, 64'h01);
    check_eq("01_lsb_bits", log_b & 64'hFF, 64'h80);
    check_eq("01_nlast", 64'(nlast), 64'd1);

    // Back-to-back A5 then 3C with in_valid held.
    log_clear();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    rdy_hits = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h3C, 1'b1, 1'b0);
    idle(9);
    check_eq("b2b_nval", 64'(nval), 64'd16);
    check_eq("b2b_nlast", 64'(nlast), 64'd2);
    check_eq("b2b_ready_hits", 64'(rdy_hits), 64'd1);
    check_eq("b2b_msb_bits", log_a & 64'hFFFF, 64'hA53C);
    check_eq("b2b_lsb_bits", log_b & 64'hFFFF, 64'hA53C);

    // F0 with a three-cycle stall after bit 2.
    log_clear();
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, W'($urandom), 1'b0, 1'b0);
    idle(7);
    check_eq("stall_nval", 64'(nval), 64'd11);
    check_eq("stall_msb_bits", log_a & 64'h7FF, 64'h7F0);
    check_eq("stall_lsb_bits", log_b & 64'h7FF, 64'h00F);

    // Reset in the middle of FF, then a clean 81.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    log_clear();
    idle(1);
    check_eq("rst_mid_nval", 64'(nval), 64'd0);
    log_clear();
    step(1'b1, 8'h81, 1'b1, 1'b0);
    idle(9);
    check_eq("post_rst_msb_bits", log_a & 64'hFF, 64'h81);
    check_eq("post_rst_lsb_bits", log_b & 64'hFF, 64'h81);
    check_eq("post_rst_nval", 64'(nval), 64'd8);

    // 55 offered mid-word, with a stall on the last bit of the first word.
    log_clear();
    ok0 = words_ok;
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    idle(9);
    check_eq("mid_nval", 64'(nval), 64'd17);
    check_eq("mid_ready_hits", 64'(rdy_hits), 64'd2);
    check_eq("mid_words_ok", 64'(words_ok - ok0), 64'd4);

    // Randomized traffic: producer holds a word until accepted; random stalls and rare resets.
    pend = 1'b0;
    rd   = '0;
    for (int i = 0; i < 3000; i++) begin
      logic sen, rst;
      if (!pend) begin
        pend = ($urandom_range(0, 2) != 0);
        rd   = W'($urandom);
      end
      sen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step(pend, pend ? rd : W'($urandom), sen, rst);
      if (m_acc || rst) pend = 1'b0;
    end
    idle(12);
    check_eq("rand_qa_drained", 64'(exp_qa.size()), 64'd0);
    check_eq("rand_qb_drained", 64'(exp_qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in serial-out transmitter for the team's shift-register serial links. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock on `sout`, with `sout_valid` and `sout_last` framing each word. It is the transmit end feeding our serial-in chains and deserializers. Back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width; legal range 2..64.
- `MSB_FIRST`, default 1:
  - 1 sends bit WIDTH-1 first.
  - 0 sends bit 0 first.
- `clk` input 1: single clock; all state updates on the falling edge of `clk`.
- `reset` input 1: synchronous, active-high reset, sampled on the falling edge of `clk`.
- `in_data` input WIDTH: parallel word to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a word this cycle.
- `shift_en` input 1: advance the serial stream this cycle; 0 stalls it.
- `sout` output 1: serial data bit (registered).
- `sout_valid` output 1: `sout` carries a word bit (registered).
- `sout_last` output 1: `sout` is the final bit of the current word (registered).
- `busy` output 1: high in SHIFT state.

## Operation
**States: IDLE, SHIFT.**
- Accept is defined as `in_valid & in_ready`.

**Readiness**
- `in_ready` = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & shift_en).
- `in_ready` is forced to 0 while `reset`=1.

**IDLE**
- On accept: load `in_data` into the shift register, drive the first bit on `sout`, set `sout_valid`=1, clear `bit_cnt` to 0, go to SHIFT.
- Otherwise: `sout_valid`=0, `sout_last`=0, `sout`=0.

**SHIFT**
- With `shift_en`=1 and `bit_cnt`<WIDTH-1: shift by one position toward the output end, present the next bit, increment `bit_cnt`.
- With `shift_en`=1 and `bit_cnt`==WIDTH-1 (last bit completes):
  - On accept: load the new word exactly as from IDLE and stay in SHIFT, with no gap.
  - Otherwise: go to IDLE and clear `sout_valid`.
- With `shift_en`=0: hold everything (`sout`, `sout_valid`, `sout_last`, `bit_cnt`). `in_ready` is 0 in this case.
- `sout_last` = 1 exactly when the registered bit being presented has index WIDTH-1 in transmit order.

**General rules**
- `in_data` is sampled only on accept; changes at any other time have no effect.
- `in_valid` asserted while SHIFT is not on its last bit gets `in_ready`=0. The producer must hold `in_valid`/`in_data` until accept.
- `shift_en` is ignored in IDLE. Accept from IDLE does not require `shift_en`.

**Reset**
- `reset` in any state, including mid-word, takes priority over everything.
- Next edge: state=IDLE, shift register=0, `bit_cnt`=0, `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0.
- The partial word is discarded, not resumed.

## Timing
- Reset values of all outputs: `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0, `in_ready`=0 while reset is asserted, then 1 (IDLE).
- Latency: the first bit is on `sout` one clock edge after the accepting edge's inputs are sampled. Accept and first-bit registration occur on the same falling edge.
- An unstalled word occupies exactly WIDTH consecutive `sout_valid` cycles; each stalled cycle adds one.
- Continuous streaming: with `in_valid` and `shift_en` held high, `sout_valid` stays 1 indefinitely and `sout_last` pulses every WIDTH cycles.
- Simultaneous `reset` and accept: reset wins, and the word is not taken.
- `bit_cnt` width is $clog2(WIDTH); it never wraps past WIDTH-1.

## Structure
- Package `piso_pkg` holds the state enum (`PISO_IDLE`, `PISO_SHIFT`) and a `PISO_CNT_W(width)` function returning $clog2(width).
- One sub-module, `piso_bit_counter`: a parameterized, synchronously resettable up-counter with clear, increment-enable, and a terminal flag at WIDTH-1.
- The datapath (shift register, bit-order mux) and the FSM live in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=1, accept 8'hA5, `shift_en`=1 -> `sout` = 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles; `sout_last`=1 only on the 8th; then `sout_valid`=0 and `in_ready`=1.
- MSB_FIRST=0, accept 8'h01 -> `sout` = 1 then seven 0s; `sout_last` on the 8th bit.
- Back-to-back 8'hA5 then 8'h3C with `in_valid` held -> 16 contiguous valid bits 10100101 00111100; `in_ready`=1 only on the last-bit cycle of the first word; two `sout_last` pulses.
- 8'hF0, `shift_en` low for 3 cycles after bit 2 -> bit 2 (value 1) held for 4 cycles, then the stream resumes; total 11 valid cycles.
- `reset` asserted after bit 4 of 8'hFF -> next edge all outputs 0; a following 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- `in_valid`=1 with 8'h55 while mid-word -> `in_ready`=0 and the word is not taken until the last-bit cycle; no bit of either word is lost or duplicated.
